// File: rtl/div_operand_stager.sv
// div_operand_stager
// Operand FIFO in front of a combinational 8-by-4 divider, plus a result
// register behind it that adds the remainder and a divide-by-zero flag.
// The head pair is presented to the divider straight from registers, so the
// divider's path runs register-to-register within a single cycle.

module div_operand_stager #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [3:0]               in_b,
    output logic [7:0]               div_a,
    output logic [3:0]               div_b,
    input  logic [7:0]               div_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_q,
    output logic [3:0]               out_r,
    output logic                     out_dz,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry layout: {dividend[7:0], divisor[3:0]}
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          out_valid_reg;
    logic [7:0]    out_q_reg;
    logic [3:0]    out_r_reg;
    logic          out_dz_reg;

    logic          push;
    logic          pop;
    logic          not_empty;
    logic [11:0]   head;
    logic [7:0]    prod;
    logic [7:0]    diff;
    logic [7:0]    q_next;
    logic [3:0]    r_next;
    logic          dz_next;

    // Handshake decisions come only from registered state, so in_ready has
    // no combinational path from in_valid or out_ready.
    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign pop       = not_empty && (!out_valid_reg || out_ready);

    // Head entry goes to the divider; an empty FIFO presents zeros rather
    // than whatever stale data sits in the unreset storage.
    assign head  = mem[rd_ptr_reg];
    assign div_a = not_empty ? head[11:4] : 8'h00;
    assign div_b = not_empty ? head[3:0]  : 4'h0;

    // Remainder is rebuilt from the divider's quotient; a zero divisor forces
    // the all-ones quotient and flags the result regardless of div_res.
    always_comb begin
        prod    = div_res * {4'h0, div_b};
        diff    = div_a - prod;
        q_next  = div_res;
        r_next  = diff[3:0];
        dz_next = 1'b0;
        if (div_b == 4'h0) begin
            q_next  = 8'hFF;
            r_next  = 4'h0;
            dz_next = 1'b1;
        end
    end

    // Operand storage: written on push, intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_a, in_b};
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Result register: loads on pop, otherwise drops valid once consumed
    // while keeping the last result values visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_q_reg     <= 8'h00;
            out_r_reg     <= 4'h0;
            out_dz_reg    <= 1'b0;
        end else if (pop) begin
            out_valid_reg <= 1'b1;
            out_q_reg     <= q_next;
            out_r_reg     <= r_next;
            out_dz_reg    <= dz_next;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_q     = out_q_reg;
    assign out_r     = out_r_reg;
    assign out_dz    = out_dz_reg;
    assign count     = count_reg;

endmodule
